// File: rtl/tap_controller.sv
// IEEE 1149.1 TAP controller with IR, bypass, 3D-config and optional IDCODE DRs.
// Ports: TCK/TRST_N (sync active-low) clock/reset; TMS, TDI serial inputs;
//   config_tdo serial out of the external 8-bit config DR; tap_state, IR
//   registered state/instruction; TDO combinational serial out; tdo_en shift
//   window. Define TAP_IDCODE_EN to build the 32-bit IDCODE register.
module tap_controller #(
  parameter logic [31:0] IDCODE_VALUE    = 32'h1000_3A01,
  parameter logic [3:0]  IR_RESET_BYPASS = 4'hF
) (
  input  logic       TCK,
  input  logic       TRST_N,
  input  logic       TMS,
  input  logic       TDI,
  input  logic       config_tdo,
  output logic [3:0] tap_state,
  output logic [3:0] IR,
  output logic       TDO,
  output logic       tdo_en
);

  typedef enum logic [3:0] {
    TLR        = 4'd0,
    RTI        = 4'd1,
    SEL_DR     = 4'd2,
    CAP_DR     = 4'd3,
    SHIFT_DR   = 4'd4,
    EXIT1_DR   = 4'd5,
    PAUSE_DR   = 4'd6,
    EXIT2_DR   = 4'd7,
    UPDATE_DR  = 4'd8,
    SEL_IR     = 4'd9,
    CAP_IR     = 4'd10,
    SHIFT_IR   = 4'd11,
    EXIT1_IR   = 4'd12,
    PAUSE_IR   = 4'd13,
    EXIT2_IR   = 4'd14,
    UPDATE_IR  = 4'd15
  } state_t;

  localparam logic [3:0] INSTR_IDCODE = 4'h1;
  localparam logic [3:0] INSTR_CONFIG = 4'h3;
  localparam logic [3:0] IR_CAPTURE   = 4'b0001;

`ifdef TAP_IDCODE_EN
  localparam logic [3:0] IR_RESET = INSTR_IDCODE;
  logic unused_ir_reset;
  assign unused_ir_reset = ^IR_RESET_BYPASS;
`else
  localparam logic [3:0] IR_RESET = IR_RESET_BYPASS;
  logic unused_idcode;
  assign unused_idcode = ^IDCODE_VALUE ^ ^INSTR_IDCODE;
`endif

  state_t     state_q;
  state_t     state_d;
  logic [3:0] ir_q;
  logic [3:0] ir_sr;
  logic       byp_q;
  logic       cfg_sel;
  logic       byp_sel;

`ifdef TAP_IDCODE_EN
  logic [31:0] id_sr;
  logic        id_sel;
  assign id_sel  = (ir_q == INSTR_IDCODE);
  assign byp_sel = !cfg_sel && !id_sel;
`else
  assign byp_sel = !cfg_sel;
`endif

  assign cfg_sel   = (ir_q == INSTR_CONFIG);
  assign tap_state = state_q;
  assign IR        = ir_q;

  // State register
  always_ff @(posedge TCK) begin
    if (!TRST_N) begin
      state_q <= TLR;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      TLR:       state_d = TMS ? TLR       : RTI;
      RTI:       state_d = TMS ? SEL_DR    : RTI;
      SEL_DR:    state_d = TMS ? SEL_IR    : CAP_DR;
      CAP_DR:    state_d = TMS ? EXIT1_DR  : SHIFT_DR;
      SHIFT_DR:  state_d = TMS ? EXIT1_DR  : SHIFT_DR;
      EXIT1_DR:  state_d = TMS ? UPDATE_DR : PAUSE_DR;
      PAUSE_DR:  state_d = TMS ? EXIT2_DR  : PAUSE_DR;
      EXIT2_DR:  state_d = TMS ? UPDATE_DR : SHIFT_DR;
      UPDATE_DR: state_d = TMS ? SEL_DR    : RTI;
      SEL_IR:    state_d = TMS ? TLR       : CAP_IR;
      CAP_IR:    state_d = TMS ? EXIT1_IR  : SHIFT_IR;
      SHIFT_IR:  state_d = TMS ? EXIT1_IR  : SHIFT_IR;
      EXIT1_IR:  state_d = TMS ? UPDATE_IR : PAUSE_IR;
      PAUSE_IR:  state_d = TMS ? EXIT2_IR  : PAUSE_IR;
      EXIT2_IR:  state_d = TMS ? UPDATE_IR : SHIFT_IR;
      UPDATE_IR: state_d = TMS ? SEL_DR    : RTI;
      default:   state_d = TLR;
    endcase
  end

  // Instruction path: actions keyed on the state being left
  always_ff @(posedge TCK) begin
    if (!TRST_N) begin
      ir_sr <= IR_CAPTURE;
      ir_q  <= IR_RESET;
    end else begin
      if (state_q == CAP_IR) begin
        ir_sr <= IR_CAPTURE;
      end else if (state_q == SHIFT_IR) begin
        ir_sr <= {TDI, ir_sr[3:1]};
      end
      if (state_q == TLR) begin
        ir_q <= IR_RESET;
      end else if (state_q == UPDATE_IR) begin
        ir_q <= ir_sr;
      end
    end
  end

  // Bypass register: captures 0 so the first shifted bit is defined
  always_ff @(posedge TCK) begin
    if (!TRST_N) begin
      byp_q <= 1'b0;
    end else if (byp_sel) begin
      if (state_q == CAP_DR) begin
        byp_q <= 1'b0;
      end else if (state_q == SHIFT_DR) begin
        byp_q <= TDI;
      end
    end
  end

`ifdef TAP_IDCODE_EN
  always_ff @(posedge TCK) begin
    if (!TRST_N) begin
      id_sr <= IDCODE_VALUE;
    end else if (state_q == CAP_DR) begin
      id_sr <= IDCODE_VALUE;
    end else if (state_q == SHIFT_DR && id_sel) begin
      id_sr <= {TDI, id_sr[31:1]};
    end
  end
`endif

  // Output logic
  always_comb begin
    TDO    = 1'b0;
    tdo_en = 1'b0;
    if (state_q == SHIFT_IR) begin
      tdo_en = 1'b1;
      TDO    = ir_sr[0];
    end else if (state_q == SHIFT_DR) begin
      tdo_en = 1'b1;
      unique case (1'b1)
        cfg_sel: TDO = config_tdo;
`ifdef TAP_IDCODE_EN
        id_sel:  TDO = id_sr[0];
`endif
        default: TDO = byp_q;
      endcase
    end
  end

endmodule

// File: tb/tb_tap_controller.sv
// Scoreboard bench for tap_controller: driver queues expectations per
// cycle, monitor pops and compares on the falling TCK edge.
module tb_tap_controller;

  logic       TCK = 1'b0;
  logic       TRST_N = 1'b0;
  logic       TMS = 1'b1;
  logic       TDI = 1'b0;
  logic       config_tdo = 1'b0;
  logic [3:0] tap_state;
  logic [3:0] IR;
  logic       TDO;
  logic       tdo_en;

  tap_controller dut (
    .TCK       (TCK),
    .TRST_N    (TRST_N),
    .TMS       (TMS),
    .TDI       (TDI),
    .config_tdo(config_tdo),
    .tap_state (tap_state),
    .IR        (IR),
    .TDO       (TDO),
    .tdo_en    (tdo_en)
  );

  always #5 TCK = ~TCK;

`ifdef TAP_IDCODE_EN
  localparam logic [3:0]  RST_IR = 4'h1;
  localparam logic [31:0] IDV    = 32'h1000_3A01;
`else
  localparam logic [3:0]  RST_IR = 4'hF;
`endif

  localparam int K_ST  = 0;
  localparam int K_IR  = 1;
  localparam int K_TDO = 2;
  localparam int K_EN  = 3;

  typedef struct {
    string       name;
    int          cyc;
    int          kind;
    logic [31:0] exp;
  } item_t;

  item_t       q[$];
  item_t       mon_it;
  logic [31:0] act;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  int walk_tms[23] = '{0,1,0,1,0,0,1,0,1,0,1,1,
                       1,1,0,1,0,1,0,1,1,0,0};
  int walk_st[23]  = '{1,2,3,5,6,6,7,4,5,6,7,8,
                       2,9,10,12,13,14,11,12,15,1,1};

  logic [7:0] cfg = 8'hA5;
  logic [3:0] pat = 4'b0101;
  logic [3:0] byp_tdo = 4'b1010;

  always @(posedge TCK) cyc <= cyc + 1;

  always @(negedge TCK) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      mon_it = q.pop_front();
      case (mon_it.kind)
        K_ST:    act = {28'd0, tap_state};
        K_IR:    act = {28'd0, IR};
        K_TDO:   act = {31'd0, TDO};
        default: act = {31'd0, tdo_en};
      endcase
      n_cmp++;
      if (act !== mon_it.exp) begin
        n_bad++;
        $display("FAIL %s @cyc %0d: got %0h, want %0h",
                 mon_it.name, cyc, act, mon_it.exp);
      end
    end
  end

  task automatic exq(input string name, input int kind,
                     input logic [31:0] exp);
    item_t it;
    it.name = name;
    it.cyc  = cyc;
    it.kind = kind;
    it.exp  = exp;
    q.push_back(it);
  endtask

  task automatic step(input logic tms, input logic tdi);
    TMS = tms;
    TDI = tdi;
    @(posedge TCK);
    #1;
  endtask

  // RTI -> shift v into IR -> RTI
  task automatic load_ir(input logic [3:0] v);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    exq("ir_shift_st", K_ST, 32'd11);
    for (int i = 0; i < 4; i++) begin
      exq("ir_tdo", K_TDO, 32'(i == 0));
      exq("ir_tdo_en", K_EN, 32'd1);
      step(i == 3, v[i]);
    end
    exq("exit1_ir_st", K_ST, 32'd12);
    exq("exit1_ir_en", K_EN, 32'd0);
    step(1'b1, 1'b0);
    exq("update_ir_st", K_ST, 32'd15);
    step(1'b0, 1'b0);
    exq("ir_loaded", K_IR, {28'd0, v});
    exq("ir_rti_st", K_ST, 32'd1);
  endtask

  task automatic enter_shift_dr();
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    exq("shift_dr_st", K_ST, 32'd4);
  endtask

  initial begin
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    exq("rst_st", K_ST, 32'd0);
    exq("rst_ir", K_IR, {28'd0, RST_IR});
    exq("rst_en", K_EN, 32'd0);
    exq("rst_tdo", K_TDO, 32'd0);
    TRST_N = 1'b1;

    for (int i = 0; i < 23; i++) begin
      step(walk_tms[i] != 0, 1'b0);
      exq("walk_st", K_ST, 32'(walk_st[i]));
    end
    exq("walk_ir", K_IR, 32'd0);

    load_ir(4'h3);
    enter_shift_dr();
    for (int i = 0; i < 8; i++) begin
      config_tdo = cfg[i];
      exq("cfg_tdo", K_TDO, {31'd0, cfg[i]});
      exq("cfg_en", K_EN, 32'd1);
      step(i == 7, 1'b0);
    end
    config_tdo = 1'b1;
    exq("cfg_exit_st", K_ST, 32'd5);
    exq("cfg_exit_en", K_EN, 32'd0);
    exq("cfg_exit_tdo", K_TDO, 32'd0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    exq("cfg_ir_kept", K_IR, 32'd3);

    load_ir(4'h7);
    enter_shift_dr();
    for (int i = 0; i < 4; i++) begin
      exq("byp_tdo", K_TDO, {31'd0, byp_tdo[i]});
      step(1'b0, pat[i]);
    end
    exq("byp_last", K_TDO, {31'd0, pat[3]});
    config_tdo = 1'b0;

    step(1'b1, 1'b0);
    exq("tms5_1", K_ST, 32'd5);
    step(1'b1, 1'b0);
    exq("tms5_2", K_ST, 32'd8);
    step(1'b1, 1'b0);
    exq("tms5_3", K_ST, 32'd2);
    step(1'b1, 1'b0);
    exq("tms5_4", K_ST, 32'd9);
    step(1'b1, 1'b0);
    exq("tms5_5", K_ST, 32'd0);
    step(1'b1, 1'b0);
    exq("tlr_ir", K_IR, {28'd0, RST_IR});
    step(1'b0, 1'b0);

    load_ir(4'h1);
    enter_shift_dr();
`ifdef TAP_IDCODE_EN
    for (int i = 0; i < 32; i++) begin
      exq("idcode_tdo", K_TDO, {31'd0, IDV[i]});
      step(1'b0, 1'b0);
    end
`else
    exq("id1_byp_0", K_TDO, 32'd0);
    step(1'b0, 1'b1);
    exq("id1_byp_1", K_TDO, 32'd1);
    step(1'b0, 1'b1);
    exq("id1_byp_2", K_TDO, 32'd1);
`endif
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);

    load_ir(4'h3);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    exq("mid_shift_st", K_ST, 32'd11);
    TRST_N = 1'b0;
    step(1'b0, 1'b0);
    exq("mid_rst_st", K_ST, 32'd0);
    exq("mid_rst_ir", K_IR, {28'd0, RST_IR});
    exq("mid_rst_en", K_EN, 32'd0);
    exq("mid_rst_tdo", K_TDO, 32'd0);
    step(1'b1, 1'b0);
    exq("mid_rst2_en", K_EN, 32'd0);
    TRST_N = 1'b1;
    step(1'b1, 1'b0);
    exq("post_rst_st", K_ST, 32'd0);
    exq("post_rst_ir", K_IR, {28'd0, RST_IR});

    @(negedge TCK);
    #1;
    if (q.size() != 0) begin
      $display("FAIL scoreboard: got %0d unchecked, want 0", q.size());
      n_bad += q.size();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/tap_controller.md
TAP_CONTROLLER -- requirements
Module: tap_controller

Interface
REQ-001 The block SHALL have parameter IDCODE_VALUE, default 32'h1000_3A01, meaning device identification word (bit 0 fixed 1).
REQ-002 The block SHALL have parameter IR_RESET_BYPASS, default 4'hF, meaning instruction loaded when IDCODE is compiled out.
REQ-003 TCK  input  1  test clock; all state changes on its rising edge.
REQ-004 TRST_N  input  1  reset, synchronous to TCK, active-low.
REQ-005 TMS  input  1  test mode select, sampled on rising TCK.
REQ-006 TDI  input  1  serial test data in.
REQ-007 config_tdo  input  1  serial output of the 8-bit 3D config data register.
REQ-008 tap_state  output  4  current TAP state encoding, registered.
REQ-009 IR  output  4  active instruction, registered.
REQ-010 TDO  output  1  serial test data out.
REQ-011 tdo_en  output  1  high while TDO carries valid shift data.

Function
REQ-012 State encoding SHALL be: 0 TEST_LOGIC_RESET, 1 RUN_TEST_IDLE, 2 SELECT_DR, 3 CAPTURE_DR, 4 SHIFT_DR, 5 EXIT1_DR, 6 PAUSE_DR, 7 EXIT2_DR, 8 UPDATE_DR, 9 SELECT_IR, 10 CAPTURE_IR, 11 SHIFT_IR, 12 EXIT1_IR, 13 PAUSE_IR, 14 EXIT2_IR, 15 UPDATE_IR.
REQ-013 Transitions SHALL follow IEEE 1149.1 on TMS: TLR(1->TLR,0->RTI); RTI(0->RTI,1->SEL_DR); SEL_DR(0->CAP_DR,1->SEL_IR); SEL_IR(0->CAP_IR,1->TLR); CAP_x(0->SHIFT_x,1->EXIT1_x); SHIFT_x(0->SHIFT_x,1->EXIT1_x); EXIT1_x(0->PAUSE_x,1->UPDATE_x); PAUSE_x(0->PAUSE_x,1->EXIT2_x); EXIT2_x(0->SHIFT_x,1->UPDATE_x); UPDATE_x(0->RTI,1->SEL_DR).
REQ-014 Five consecutive TMS=1 edges SHALL reach TEST_LOGIC_RESET from any state.
REQ-015 Instructions SHALL decode: 4'h1 IDCODE, 4'h3 CONFIG_3D, 4'hF BYPASS; every other code SHALL select the bypass register.
REQ-016 A 4-bit IR shift register SHALL load 4'b0001 on the edge leaving CAPTURE_IR state, shift right with TDI into bit 3 in SHIFT_IR, and hold in all other states.
REQ-017 IR SHALL take the IR shift register value on the rising edge where tap_state is UPDATE_IR; no other state changes IR except TEST_LOGIC_RESET.
REQ-018 While tap_state is TEST_LOGIC_RESET, IR SHALL be forced to the reset instruction on every edge.
REQ-019 Bypass register (1 bit) SHALL load 0 in CAPTURE_DR and load TDI in SHIFT_DR when bypass is selected.
REQ-020 TDO SHALL be combinational: SHIFT_IR -> IR shift bit 0; SHIFT_DR with CONFIG_3D -> config_tdo; SHIFT_DR with IDCODE -> IDCODE shift bit 0; SHIFT_DR otherwise -> bypass bit; all other states -> 0.
REQ-021 tdo_en SHALL be 1 exactly when tap_state is SHIFT_DR or SHIFT_IR.
REQ-022 Datapath registers act on the edge where tap_state equals the action state; tap_state therefore SHALL change on the same edge, giving one edge of action per state visit.

Reset
REQ-023 TRST_N=0 sampled on a rising TCK SHALL set tap_state to 0, IR to the reset instruction, IR shift to 4'b0001, bypass to 0, IDCODE shift to IDCODE_VALUE.
REQ-024 Reset mid-shift SHALL discard partial IR/DR contents; IR SHALL not update.
REQ-025 During reset tdo_en and TDO SHALL be 0 from the cycle after the reset edge.

Configuration
REQ-026 Macro TAP_IDCODE_EN: when defined, a 32-bit IDCODE shift register SHALL load IDCODE_VALUE in CAPTURE_DR, shift right with TDI into bit 31 in SHIFT_DR under IDCODE, and the reset instruction SHALL be 4'h1.
REQ-027 When TAP_IDCODE_EN is undefined, no IDCODE register SHALL exist, 4'h1 SHALL decode as BYPASS, and the reset instruction SHALL be IR_RESET_BYPASS.

Verification
REQ-028 Reset, then TMS=1 x5 from SHIFT_DR -> tap_state=0 on fifth edge, IR=4'h1 (4'hF without macro).
REQ-029 Load IR 4'h3 via SHIFT_IR (TDI 1,1,0,0 LSB first) -> TDO in SHIFT_IR shows 1,0,0,0; IR=4'h3 one edge after UPDATE_IR.
REQ-030 With IR=4'h3, shift 8 bits 8'hA5 through DR -> TDO follows config_tdo; tdo_en=1 only during the 8 SHIFT_DR edges.
REQ-031 IDCODE (macro on): reset, CAPTURE_DR, 32 shifts -> TDO emits 32'h1000_3A01 LSB first.
REQ-032 IR=4'h7 (undefined), shift DR with TDI pattern 1,0,1 -> TDO = 0,1,0 (one-bit bypass delay).
REQ-033 TRST_N=0 asserted during SHIFT_IR after 2 bits -> tap_state=0 next edge, IR unchanged to reset instruction, no UPDATE_IR effect.
